// File: rtl/dmem_responder.sv
// dmem_responder: RAM-side responder for the CPU data-memory interface.
// Serves one byte/halfword/word load or store at a time from a word array
// with byte lanes. Load results are sign- or zero-extended. Each request ends
// with a one-cycle ready pulse that carries an error flag.
// Optional feature: define DMEM_MMIO_EN to add a word-wide MMIO register at MMIO_ADDR.
module dmem_responder #(
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 0,
  parameter logic [31:0] MMIO_ADDR = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_write_data,
  input  logic        mem_write_enable,
  input  logic        mem_read_enable,
  input  logic [2:0]  mem_funct3,
  output logic [31:0] mem_read_data,
  output logic        mem_ready,
  output logic        mem_error,
  output logic        mem_busy
`ifdef DMEM_MMIO_EN
  ,
  output logic [31:0] mmio_out
`endif
);

  localparam int          IDXW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_W   = 32'(DEPTH);
  localparam logic [3:0]  WAIT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} stateT;

  stateT       state;
  logic [3:0]  waitCount;
  logic [31:0] addrQ;
  logic [31:0] dataQ;
  logic [2:0]  funct3Q;
  logic        isWrite;

  logic [31:0] mem [DEPTH];

  logic [IDXW-1:0] wordIdx;
  logic            badFunct3;
  logic            misaligned;
  logic            outOfRange;
  logic            mmioHit;
  logic            mmioBad;
  logic            accessErr;
  logic            doStore;
  logic [3:0]      laneMask;
  logic [31:0]     laneData;
  logic [31:0]     rawWord;
  logic [31:0]     laneWord;
  logic [31:0]     loadResult;

  assign wordIdx  = addrQ[IDXW+1:2];
  assign mem_busy = (state != IDLE);

`ifdef DMEM_MMIO_EN
  assign mmioHit = (addrQ == MMIO_ADDR);
`else
  assign mmioHit = 1'b0;
`endif

  // Request legality: size code, natural alignment, and array range (MMIO overrides range).
  always_comb begin
    badFunct3  = 1'b0;
    misaligned = 1'b0;
    outOfRange = 1'b0;
    mmioBad    = 1'b0;
    if (isWrite) begin
      badFunct3 = !(funct3Q inside {3'b000, 3'b001, 3'b010});
    end else begin
      badFunct3 = (funct3Q inside {3'b011, 3'b110, 3'b111});
    end
    case (funct3Q[1:0])
      2'b01:   misaligned = addrQ[0];
      2'b10:   misaligned = (addrQ[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
    outOfRange = !mmioHit && ({2'b00, addrQ[31:2]} >= DEPTH_W);
    mmioBad    = mmioHit && (funct3Q != 3'b010);
    accessErr  = badFunct3 || misaligned || outOfRange || mmioBad;
    doStore    = (state == ACCESS) && isWrite && !accessErr && !mmioHit;
  end

  // Store lane selection: replicate the right-aligned data across lanes and enable only the targeted ones.
  always_comb begin
    laneMask = 4'b0000;
    laneData = dataQ;
    case (funct3Q[1:0])
      2'b00: begin
        laneMask = 4'b0001 << addrQ[1:0];
        laneData = {4{dataQ[7:0]}};
      end
      2'b01: begin
        laneMask = addrQ[1] ? 4'b1100 : 4'b0011;
        laneData = {2{dataQ[15:0]}};
      end
      default: begin
        laneMask = 4'b1111;
        laneData = dataQ;
      end
    endcase
  end

  // Load path: fetch the word, shift the addressed byte/half down to bit 0, then extend.
  always_comb begin
    rawWord = mem[wordIdx];
`ifdef DMEM_MMIO_EN
    if (mmioHit) begin
      rawWord = mmio_out;
    end
`endif
    laneWord = rawWord >> {addrQ[1:0], 3'b000};
    case (funct3Q)
      3'b000:  loadResult = {{24{laneWord[7]}}, laneWord[7:0]};
      3'b100:  loadResult = {24'd0, laneWord[7:0]};
      3'b001:  loadResult = {{16{laneWord[15]}}, laneWord[15:0]};
      3'b101:  loadResult = {16'd0, laneWord[15:0]};
      3'b010:  loadResult = rawWord;
      default: loadResult = 32'd0;
    endcase
  end

  // Array write port: only on the ACCESS edge of a legal store, never while reset is asserted.
  always_ff @(posedge clk) begin
    if (!rst && doStore) begin
      for (int i = 0; i < 4; i++) begin
        if (laneMask[i]) begin
          mem[wordIdx][8*i +: 8] <= laneData[8*i +: 8];
        end
      end
    end
  end

  // Request sequencer: latch in IDLE, optional wait, one access edge, one-cycle response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      waitCount     <= 4'd0;
      addrQ         <= 32'd0;
      dataQ         <= 32'd0;
      funct3Q       <= 3'd0;
      isWrite       <= 1'b0;
      mem_read_data <= 32'd0;
      mem_ready     <= 1'b0;
      mem_error     <= 1'b0;
`ifdef DMEM_MMIO_EN
      mmio_out      <= 32'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (mem_write_enable || mem_read_enable) begin
            addrQ     <= mem_addr;
            dataQ     <= mem_write_data;
            funct3Q   <= mem_funct3;
            isWrite   <= mem_write_enable;
            waitCount <= WAIT_INIT;
            state     <= (LATENCY > 0) ? WAIT : ACCESS;
          end
        end
        WAIT: begin
          if (waitCount == 4'd0) begin
            state <= ACCESS;
          end else begin
            waitCount <= waitCount - 4'd1;
          end
        end
        ACCESS: begin
          mem_ready <= 1'b1;
          mem_error <= accessErr;
          if (!isWrite) begin
            mem_read_data <= accessErr ? 32'd0 : loadResult;
          end
`ifdef DMEM_MMIO_EN
          if (isWrite && mmioHit && !accessErr) begin
            mmio_out <= dataQ;
          end
`endif
          state <= RESP;
        end
        RESP: begin
          mem_ready <= 1'b0;
          mem_error <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed table, hand-written timing/reset sequences and
// randomized traffic against a byte-level memory model for dmem_responder.
// Unit A runs with LATENCY=0, unit B with LATENCY=3 for wait-state timing.
module tb_dmem_responder;

  localparam int          DEPTH_A = 1024;
  localparam logic [31:0] MMIO    = 32'hFFFF_FF00;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [31:0] addrA = '0, wdataA = '0, rdataA;
  logic        weA = 1'b0, reA = 1'b0, readyA, errA, busyA;
  logic [2:0]  f3A = '0;
  logic [31:0] addrB = '0, wdataB = '0, rdataB;
  logic        weB = 1'b0, reB = 1'b0, readyB, errB, busyB;
  logic [2:0]  f3B = '0;
`ifdef DMEM_MMIO_EN
  logic [31:0] mmioA, mmioB;
`endif

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0]  refMem [DEPTH_A*4];
  logic [31:0] refLastRead;
  logic [31:0] refMmio;

  typedef struct {
    bit          we;
    bit          re;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expData;
    bit          expErr;
    string       name;
  } vecT;

  vecT vecs[$];

  dmem_responder #(.DEPTH(DEPTH_A), .LATENCY(0), .MMIO_ADDR(MMIO)) dutA (
    .clk(clk), .rst(rst),
    .mem_addr(addrA), .mem_write_data(wdataA),
    .mem_write_enable(weA), .mem_read_enable(reA), .mem_funct3(f3A),
    .mem_read_data(rdataA), .mem_ready(readyA), .mem_error(errA), .mem_busy(busyA)
`ifdef DMEM_MMIO_EN
    , .mmio_out(mmioA)
`endif
  );

  dmem_responder #(.DEPTH(64), .LATENCY(3), .MMIO_ADDR(MMIO)) dutB (
    .clk(clk), .rst(rst),
    .mem_addr(addrB), .mem_write_data(wdataB),
    .mem_write_enable(weB), .mem_read_enable(reB), .mem_funct3(f3B),
    .mem_read_data(rdataB), .mem_ready(readyB), .mem_error(errB), .mem_busy(busyB)
`ifdef DMEM_MMIO_EN
    , .mmio_out(mmioB)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic vecT mk(bit we, bit re, logic [2:0] f3, logic [31:0] addr,
                             logic [31:0] wdata, logic [31:0] expData, bit expErr, string name);
    vecT v;
    v.we = we; v.re = re; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.expData = expData; v.expErr = expErr; v.name = name;
    return v;
  endfunction

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drives one request in the next cycle and waits (bounded) for its ready pulse.
  task automatic applyStimulus(input bit slow, input bit we, input bit re, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wd,
                               output logic [31:0] rdata, output logic err, output int cycles);
    @(negedge clk);
    if (slow) begin
      weB = we; reB = re; f3B = f3; addrB = addr; wdataB = wd;
    end else begin
      weA = we; reA = re; f3A = f3; addrA = addr; wdataA = wd;
    end
    @(negedge clk);
    cycles = 1;
    weA = 1'b0; reA = 1'b0; weB = 1'b0; reB = 1'b0;
    while (!(slow ? readyB : readyA) && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    rdata = slow ? rdataB : rdataA;
    err   = slow ? errB : errA;
  endtask

  task automatic doReset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Reference model: byte-addressed memory, access size/sign from funct3, held read data.
  task automatic modelAccess(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, output logic [31:0] expData, output bit expErr);
    int     size = 0;
    bit     sgn  = 0;
    bit     bad  = 0;
    bit     mmio = 0;
    longint val  = 0;
    if (we) begin
      case (f3)
        3'd0: size = 1;
        3'd1: size = 2;
        3'd2: size = 4;
        default: bad = 1;
      endcase
    end else begin
      case (f3)
        3'd0: begin size = 1; sgn = 1; end
        3'd1: begin size = 2; sgn = 1; end
        3'd2: size = 4;
        3'd4: size = 1;
        3'd5: size = 2;
        default: bad = 1;
      endcase
    end
    if (!bad && (addr % size) != 0) bad = 1;
`ifdef DMEM_MMIO_EN
    mmio = (addr == MMIO);
    if (mmio && size != 4) bad = 1;
`endif
    if (!bad && !mmio && (longint'(addr) / 4) >= DEPTH_A) bad = 1;
    expErr = bad;
    if (bad) begin
      if (!we) refLastRead = 32'd0;
    end else if (we) begin
      if (mmio) refMmio = wd;
      else for (int i = 0; i < size; i++) refMem[addr + i] = 8'(wd >> (8 * i));
    end else begin
      if (mmio) val = longint'(refMmio);
      else for (int i = 0; i < size; i++) val += longint'(refMem[addr + i]) << (8 * i);
      if (sgn && val >= (64'sd1 << (8 * size - 1))) val -= (64'sd1 << (8 * size));
      refLastRead = 32'(val);
    end
    expData = refLastRead;
  endtask

  initial begin
    logic [31:0] rdata, expData;
    logic        err;
    bit          expErr;
    int          cycles;
    int          sawReady;

    vecs.push_back(mk(1, 0, 3'd2, 32'h10, 32'hDEADBEEF, 32'h00000000, 0, "SW 0x10"));
    vecs.push_back(mk(0, 1, 3'd2, 32'h10, 32'h0,        32'hDEADBEEF, 0, "LW 0x10"));
    vecs.push_back(mk(1, 0, 3'd0, 32'h11, 32'h0000007F, 32'hDEADBEEF, 0, "SB 0x11"));
    vecs.push_back(mk(0, 1, 3'd0, 32'h11, 32'h0,        32'h0000007F, 0, "LB 0x11"));
    vecs.push_back(mk(0, 1, 3'd2, 32'h10, 32'h0,        32'hDEAD7FEF, 0, "LW 0x10 after SB"));
    vecs.push_back(mk(0, 1, 3'd4, 32'h13, 32'h0,        32'h000000DE, 0, "LBU 0x13"));
    vecs.push_back(mk(0, 1, 3'd0, 32'h13, 32'h0,        32'hFFFFFFDE, 0, "LB 0x13"));
    vecs.push_back(mk(0, 1, 3'd1, 32'h12, 32'h0,        32'hFFFFDEAD, 0, "LH 0x12"));
    vecs.push_back(mk(0, 1, 3'd5, 32'h12, 32'h0,        32'h0000DEAD, 0, "LHU 0x12"));
    vecs.push_back(mk(0, 1, 3'd2, 32'h12, 32'h0,        32'h00000000, 1, "LW misaligned"));
    vecs.push_back(mk(1, 0, 3'd1, 32'h11, 32'h0000BEEF, 32'h00000000, 1, "SH misaligned"));
    vecs.push_back(mk(0, 1, 3'd2, 32'h1000, 32'h0,      32'h00000000, 1, "LW out of range"));
    vecs.push_back(mk(0, 1, 3'd2, 32'h10, 32'h0,        32'hDEAD7FEF, 0, "LW 0x10 unchanged"));
    vecs.push_back(mk(1, 1, 3'd2, 32'h20, 32'h12345678, 32'hDEAD7FEF, 0, "both enables SW 0x20"));
    vecs.push_back(mk(0, 1, 3'd2, 32'h20, 32'h0,        32'h12345678, 0, "LW 0x20"));
    vecs.push_back(mk(0, 1, 3'd3, 32'h20, 32'h0,        32'h00000000, 1, "load funct3 011"));
    vecs.push_back(mk(1, 0, 3'd4, 32'h30, 32'hFFFFFFFF, 32'h00000000, 1, "store funct3 100"));
    vecs.push_back(mk(1, 0, 3'd2, 32'h24, 32'hCAFEF00D, 32'h00000000, 0, "SW 0x24"));
    vecs.push_back(mk(0, 1, 3'd2, 32'h24, 32'h0,        32'hCAFEF00D, 0, "LW 0x24"));
    vecs.push_back(mk(1, 0, 3'd1, 32'h26, 32'hAAAA1234, 32'hCAFEF00D, 0, "SH 0x26"));
    vecs.push_back(mk(0, 1, 3'd2, 32'h24, 32'h0,        32'h1234F00D, 0, "LW 0x24 after SH"));
    vecs.push_back(mk(1, 0, 3'd2, 32'h24, 32'hCAFEF00D, 32'h1234F00D, 0, "SW 0x24 restore"));
`ifndef DMEM_MMIO_EN
    vecs.push_back(mk(0, 1, 3'd2, MMIO, 32'h0,          32'h00000000, 1, "LW MMIO_ADDR plain"));
`endif

    doReset();
    checkOutput("reset A read_data", rdataA, 32'd0);
    checkOutput("reset A ready", 32'(readyA), 32'd0);
    checkOutput("reset A error", 32'(errA), 32'd0);
    checkOutput("reset A busy", 32'(busyA), 32'd0);
    checkOutput("reset B busy", 32'(busyB), 32'd0);
`ifdef DMEM_MMIO_EN
    checkOutput("reset A mmio_out", mmioA, 32'd0);
`endif

    foreach (vecs[i]) begin
      applyStimulus(0, vecs[i].we, vecs[i].re, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rdata, err, cycles);
      checkOutput({vecs[i].name, " cycles"}, cycles, 2);
      checkOutput({vecs[i].name, " data"}, rdata, vecs[i].expData);
      checkOutput({vecs[i].name, " error"}, 32'(err), 32'(vecs[i].expErr));
    end

    @(negedge clk);
    weA = 1'b1; f3A = 3'd2; addrA = 32'h24; wdataA = 32'h11111111;
    @(negedge clk);
    weA = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sawReady = 0;
    for (int c = 0; c < 5; c++) begin
      if (readyA) sawReady++;
      @(negedge clk);
    end
    checkOutput("reset mid-op ready pulses", sawReady, 0);
    checkOutput("reset mid-op busy", 32'(busyA), 32'd0);
    applyStimulus(0, 0, 1, 3'd2, 32'h24, 32'h0, rdata, err, cycles);
    checkOutput("LW 0x24 after aborted SW", rdata, 32'hCAFEF00D);
    checkOutput("LW 0x24 after aborted SW error", 32'(err), 32'd0);

`ifdef DMEM_MMIO_EN
    applyStimulus(0, 1, 0, 3'd2, MMIO, 32'h000000A5, rdata, err, cycles);
    checkOutput("SW MMIO error", 32'(err), 32'd0);
    checkOutput("SW MMIO mmio_out", mmioA, 32'h000000A5);
    applyStimulus(0, 0, 1, 3'd2, MMIO, 32'h0, rdata, err, cycles);
    checkOutput("LW MMIO data", rdata, 32'h000000A5);
    checkOutput("LW MMIO error", 32'(err), 32'd0);
    applyStimulus(0, 1, 0, 3'd0, MMIO, 32'h0000003C, rdata, err, cycles);
    checkOutput("SB MMIO error", 32'(err), 32'd1);
    checkOutput("SB MMIO mmio_out", mmioA, 32'h000000A5);
`endif

    @(negedge clk);
    weB = 1'b1; f3B = 3'd2; addrB = 32'h8; wdataB = 32'h55AA55AA;
    sawReady = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1 || c == 3 || c == 6) weB = 1'b0;
      checkOutput($sformatf("B ready cycle %0d", c), 32'(readyB), 32'(c == 5));
      checkOutput($sformatf("B busy cycle %0d", c), 32'(busyB), 32'(c >= 1 && c <= 5));
      if (c == 2 || c == 5) begin
        weB = 1'b1; addrB = 32'h8; wdataB = 32'h0;
      end
    end
    applyStimulus(1, 0, 1, 3'd2, 32'h8, 32'h0, rdata, err, cycles);
    checkOutput("B LW cycles", cycles, 5);
    checkOutput("B LW data", rdata, 32'h55AA55AA);
    checkOutput("B LW error", 32'(err), 32'd0);

    applyStimulus(0, 0, 1, 3'd2, 32'h24, 32'h0, rdata, err, cycles);
    checkOutput("LW 0x24 before random", rdata, 32'hCAFEF00D);
    refLastRead = 32'hCAFEF00D;
    refMmio     = 32'h000000A5;
    for (int w = 0; w < 64; w++) begin
      logic [31:0] d = $urandom;
      modelAccess(1, 3'd2, 32'(4 * w), d, expData, expErr);
      applyStimulus(0, 1, 0, 3'd2, 32'(4 * w), d, rdata, err, cycles);
      checkOutput("init SW error", 32'(err), 32'(expErr));
    end

    for (int n = 0; n < 200; n++) begin
      int          kind = $urandom_range(0, 2);
      bit          we   = (kind != 0);
      bit          re   = (kind != 1);
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd   = $urandom;
      if ($urandom_range(0, 9) < 8) begin
        int pick = we ? $urandom_range(0, 2) : $urandom_range(0, 4);
        f3 = (pick < 3) ? 3'(pick) : 3'(pick + 1);
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 9) < 9) addr = 32'($urandom_range(0, 255));
      else addr = $urandom_range(32'h00001000, 32'hFFFFFFFF);
      modelAccess(we, f3, addr, wd, expData, expErr);
      applyStimulus(0, we, re, f3, addr, wd, rdata, err, cycles);
      checkOutput($sformatf("rand %0d cycles", n), cycles, 2);
      checkOutput($sformatf("rand %0d data (we=%0d f3=%0d addr=%h)", n, we, f3, addr), rdata, expData);
      checkOutput($sformatf("rand %0d error (we=%0d f3=%0d addr=%h)", n, we, f3, addr), 32'(err), 32'(expErr));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
